// File: rtl/hash_verifier_if.sv
// hash_verifier_if: request and result valid/ready channels of the digest checker
//   master: requester side (drives in_*, res_ready)
//   slave : checker side (drives in_ready, res_*)
interface hash_verifier_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_m;
    logic [31:0] in_iv;
    logic [31:0] in_exp;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_digest;
    logic        res_match;
    modport master (
        output in_valid, in_m, in_iv, in_exp, res_ready,
        input  in_ready, res_valid, res_digest, res_match
    );
    modport slave (
        input  in_valid, in_m, in_iv, in_exp, res_ready,
        output in_ready, res_valid, res_digest, res_match
    );
endinterface

// File: rtl/hash_verifier.sv
// hash_verifier: recomputes a 4-byte iterative digest, one round per clock, and flags mismatches
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : request (in_*) and result (res_*) valid/ready channels
//   busy      : high while computing or holding a result
//   clr_count : synchronous clear of err_count (wins over an increment)
//   err_count : saturating count of mismatching results consumed
module hash_verifier #(
    parameter int ROUNDS = 24,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hash_verifier_if.slave   bus,
    output logic             busy,
    input  logic             clr_count,
    output logic [CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, ROUND, RESULT} state_t;
    state_t           state_q, state_d;
    logic [31:0]      h_q, h_d, iv_q, iv_d, exp_q, exp_d, dig_q, dig_d;
    logic             match_q, match_d;
    logic [7:0]       rnd_q, rnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      h_new, dig_new;
    // The add is done at 9 bits so it never wraps; s < 2*0xFD, so one subtraction reduces mod 0xFD.
    for (genvar g = 0; g < 4; g++) begin : g_byte
        logic [8:0] s;
        assign s = {1'b0, h_q[8*g +: 8] ^ iv_q[8*g +: 8]} + 9'h085;
        assign h_new[8*g +: 8] = (s >= 9'h0FD) ? 8'(s - 9'h0FD) : s[7:0];
        assign dig_new[8*g +: 8] = h_new[8*(3-g) +: 8] ^ iv_q[8*g +: 8];
    end
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        iv_d    = iv_q;
        exp_d   = exp_q;
        dig_d   = dig_q;
        match_d = match_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                iv_d    = bus.in_iv;
                exp_d   = bus.in_exp;
                h_d     = bus.in_m ^ bus.in_iv;
                rnd_d   = 8'd0;
                state_d = ROUND;
            end
            ROUND: begin
                h_d   = h_new;
                rnd_d = rnd_q + 8'd1;
                if (rnd_q == 8'(ROUNDS - 1)) begin
                    state_d = RESULT;
                    dig_d   = dig_new;
                    match_d = dig_new == exp_q;
                end
            end
            RESULT: if (bus.res_ready) begin
                state_d = IDLE;
                cnt_d   = (!match_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
            end
            default: state_d = IDLE;
        endcase
        if (clr_count) cnt_d = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            iv_q    <= '0;
            exp_q   <= '0;
            dig_q   <= '0;
            match_q <= 1'b0;
            rnd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            iv_q    <= iv_d;
            exp_q   <= exp_d;
            dig_q   <= dig_d;
            match_q <= match_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.in_ready   = state_q == IDLE;
    assign bus.res_valid  = state_q == RESULT;
    assign bus.res_digest = dig_q;
    assign bus.res_match  = match_q;
    assign busy           = state_q != IDLE;
    assign err_count      = cnt_q;
endmodule

// File: tb/tb_hash_verifier.sv
// tb_hash_verifier: directed checks of hash_verifier at ROUNDS=1, 2 and 24
module tb_hash_verifier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    hash_verifier_if h1();
    hash_verifier_if h2();
    hash_verifier_if h24();
    logic clr1 = 1'b0, clr2 = 1'b0, clr24 = 1'b0;
    logic busy1, busy2, busy24;
    logic [15:0] err1, err2;
    logic [1:0] err24;
    hash_verifier #(.ROUNDS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(h1), .busy(busy1), .clr_count(clr1), .err_count(err1));
    hash_verifier #(.ROUNDS(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(h2), .busy(busy2), .clr_count(clr2), .err_count(err2));
    hash_verifier #(.ROUNDS(24), .CNT_W(2)) u24 (.clk(clk), .rst_n(rst_n), .bus(h24), .busy(busy24), .clr_count(clr24), .err_count(err24));

    // Independent reference: each round is (byte ^ iv + 0x85) mod 0xFD, digest byte i = H[3-i] ^ iv[i].
    function automatic logic [31:0] ref_hash(input logic [31:0] m, input logic [31:0] iv, input int rounds);
        int hb[4];
        logic [31:0] d;
        for (int i = 0; i < 4; i++) hb[i] = int'(m[8*i +: 8] ^ iv[8*i +: 8]);
        for (int r = 0; r < rounds; r++)
            for (int i = 0; i < 4; i++) hb[i] = ((hb[i] ^ int'(iv[8*i +: 8])) + 133) % 253;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(hb[3-i]) ^ iv[8*i +: 8];
        return d;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({h1.in_ready, h1.res_valid, h1.res_match, busy1} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1000", {h1.in_ready, h1.res_valid, h1.res_match, busy1});
        end
        checks++;
        if (h1.res_digest !== 32'h0) begin
            failures++;
            $display("FAIL reset_digest got=%h exp=00000000", h1.res_digest);
        end
        checks++;
        if ({err1, err2, err24} !== 34'h0) begin
            failures++;
            $display("FAIL reset_err got=%h/%h/%h exp=0", err1, err2, err24);
        end
        rst_n = 1'b1;
    endtask

    task automatic run1(input logic [31:0] m, input logic [31:0] iv, input logic [31:0] ex,
                        input logic [31:0] dig, input logic mt, input logic [15:0] er, input string nm);
        @(negedge clk);
        h1.in_m = m; h1.in_iv = iv; h1.in_exp = ex; h1.in_valid = 1'b1; h1.res_ready = 1'b0;
        checks++;
        if (h1.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready got=%b exp=1", nm, h1.in_ready);
        end
        @(negedge clk);
        h1.in_valid = 1'b0;
        checks++;
        if ({h1.res_valid, busy1, h1.in_ready} !== 3'b010) begin
            failures++;
            $display("FAIL %s_round got=%b exp=010", nm, {h1.res_valid, busy1, h1.in_ready});
        end
        @(negedge clk);
        checks++;
        if (h1.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency res_valid got=%b exp=1", nm, h1.res_valid);
        end
        checks++;
        if (h1.res_digest !== dig) begin
            failures++;
            $display("FAIL %s_digest got=%h exp=%h", nm, h1.res_digest, dig);
        end
        checks++;
        if (h1.res_match !== mt) begin
            failures++;
            $display("FAIL %s_match got=%b exp=%b", nm, h1.res_match, mt);
        end
        h1.res_ready = 1'b1;
        @(negedge clk);
        h1.res_ready = 1'b0;
        checks++;
        if (err1 !== er) begin
            failures++;
            $display("FAIL %s_err got=%0d exp=%0d", nm, err1, er);
        end
        checks++;
        if ({h1.in_ready, h1.res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL %s_idle got=%b exp=10", nm, {h1.in_ready, h1.res_valid});
        end
    endtask

    task automatic test_single_round;
        run1(32'h0, 32'h0, 32'h85858585, 32'h85858585, 1'b1, 16'd0, "zero");
        run1(32'hFFFFFFFF, 32'h0, 32'h0, 32'h87878787, 1'b0, 16'd1, "reduce");
        run1(32'h00000003, 32'h0, 32'h88858585, 32'h88858585, 1'b1, 16'd1, "reverse");
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        h2.in_m = 32'h0; h2.in_iv = 32'h0; h2.in_exp = 32'h0; h2.in_valid = 1'b1; h2.res_ready = 1'b0;
        @(negedge clk);
        h2.in_m = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (h2.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_early res_valid got=%b exp=0", h2.res_valid);
        end
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({h2.res_valid, h2.in_ready, h2.res_digest} !== {2'b10, 32'h0D0D0D0D}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%b%b_%h exp=10_0d0d0d0d", k, h2.res_valid, h2.in_ready, h2.res_digest);
            end
            @(negedge clk);
        end
        h2.in_valid = 1'b0;
        h2.res_ready = 1'b1;
        @(negedge clk);
        h2.res_ready = 1'b0;
        checks++;
        if (err2 !== 16'd1) begin
            failures++;
            $display("FAIL bp_err got=%0d exp=1", err2);
        end
        @(negedge clk);
        checks++;
        if ({h2.in_ready, h2.res_valid, busy2} !== 3'b100) begin
            failures++;
            $display("FAIL bp_no_second got=%b exp=100", {h2.in_ready, h2.res_valid, busy2});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        int prev;
        int n;
        r = ref_hash(32'h12345678, 32'h9ABCDEF0, 24);
        prev = 0;
        @(negedge clk);
        h24.in_m = 32'h12345678; h24.in_iv = 32'h9ABCDEF0; h24.in_exp = r ^ 32'h1;
        h24.in_valid = 1'b1; h24.res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (h24.res_valid !== 1'b1 && n < 40);
            checks++;
            if (h24.res_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_timeout req=%0d res_valid got=%b exp=1", k, h24.res_valid);
            end
            checks++;
            if ({h24.res_digest, h24.res_match} !== {r, 1'b0}) begin
                failures++;
                $display("FAIL b2b_result req=%0d got=%h/%b exp=%h/0", k, h24.res_digest, h24.res_match, r);
            end
            checks++;
            if (err24 !== 2'((k > 3) ? 3 : k)) begin
                failures++;
                $display("FAIL b2b_err req=%0d got=%0d exp=%0d", k, err24, (k > 3) ? 3 : k);
            end
            if (k > 0) begin
                checks++;
                if (cyc - prev !== 26) begin
                    failures++;
                    $display("FAIL b2b_period req=%0d got=%0d exp=26", k, cyc - prev);
                end
            end
            prev = cyc;
            if (k == 4) begin
                clr24 = 1'b1;
                h24.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        clr24 = 1'b0;
        h24.res_ready = 1'b0;
        checks++;
        if (err24 !== 2'd0) begin
            failures++;
            $display("FAIL b2b_clear got=%0d exp=0", err24);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        r = ref_hash(32'hA5A5A5A5, 32'h0F0F0F0F, 24);
        @(negedge clk);
        h24.in_m = 32'hA5A5A5A5; h24.in_iv = 32'h0F0F0F0F; h24.in_exp = r; h24.in_valid = 1'b1;
        @(negedge clk);
        h24.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({h24.in_ready, h24.res_valid, busy24} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid_state got=%b exp=100", {h24.in_ready, h24.res_valid, busy24});
        end
        checks++;
        if (err2 !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid_err got=%0d exp=0", err2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        h24.in_valid = 1'b1;
        @(negedge clk);
        h24.in_valid = 1'b0;
        repeat (23) @(negedge clk);
        checks++;
        if (h24.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_after_early res_valid got=%b exp=0", h24.res_valid);
        end
        @(negedge clk);
        checks++;
        if ({h24.res_valid, h24.res_match, h24.res_digest} !== {2'b11, r}) begin
            failures++;
            $display("FAIL rst_after_result got=%b%b_%h exp=11_%h", h24.res_valid, h24.res_match, h24.res_digest, r);
        end
        h24.res_ready = 1'b1;
        @(negedge clk);
        h24.res_ready = 1'b0;
        checks++;
        if ({h24.in_ready, err24} !== 3'b100) begin
            failures++;
            $display("FAIL rst_after_done got=%b exp=100", {h24.in_ready, err24});
        end
    endtask

    initial begin
        h1.in_valid = 1'b0; h1.in_m = '0; h1.in_iv = '0; h1.in_exp = '0; h1.res_ready = 1'b0;
        h2.in_valid = 1'b0; h2.in_m = '0; h2.in_iv = '0; h2.in_exp = '0; h2.res_ready = 1'b0;
        h24.in_valid = 1'b0; h24.in_m = '0; h24.in_iv = '0; h24.in_exp = '0; h24.res_ready = 1'b0;
        test_reset;
        test_single_round;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hash_verifier.md
# hash_verifier

Receiver-side digest checker for the team's 4-byte iterative hash. It accepts a message, an IV and an expected digest over a valid/ready handshake. It recomputes the digest with one compression round per clock and returns the recomputed digest plus a match flag over a second valid/ready handshake. It sits downstream of the hash producer and the link, and flags corrupted message/digest pairs.

## Interface
- ROUNDS, 24: number of compression rounds. Legal values are 1..255.
- CNT_W, 16: width of the mismatch counter.
- Reset is rst_n, asynchronous, active-low. Clock is clk.
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when high together with in_valid.
- in_m  in  32  message. Byte i is bits [8i+7:8i].
- in_iv  in  32  IV, same byte order.
- in_exp  in  32  expected digest, same byte order.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when high together with res_valid.
- res_digest  out  32  recomputed digest.
- res_match  out  1  1 when res_digest == captured in_exp.
- busy  out  1  high in ROUND and RESULT.
- clr_count  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating count of mismatching results consumed.

## Operation
- FSM states: IDLE, ROUND, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register iv=in_iv and exp=in_exp.
  - Set H[i]=in_m[i]^in_iv[i] and rnd=0.
  - Go to ROUND.
- ROUND, one round per cycle:
  - s = {1'b0, H[i]^iv[i]} + 9'h085. The range of s is 0x085..0x184.
  - H[i] <= (s >= 9'h0FD) ? s-9'h0FD : s, truncated to 8 bits. At most one subtraction is ever needed.
  - rnd <= rnd+1.
  - When the cycle performing round number ROUNDS-1 completes, go to RESULT. On that same edge register res_digest byte i = H_new[3-i]^iv[i] and res_match = (digest == exp).
- RESULT:
  - res_valid=1.
  - res_digest and res_match hold stable until res_ready.
  - On res_valid&&res_ready: go to IDLE.
  - If res_match==0 on that handshake, err_count increments, saturating at all-ones.
- in_ready is 0 in ROUND and RESULT. in_* inputs are ignored outside the IDLE handshake.
- clr_count sets err_count to 0 on the next edge. If clr_count coincides with a mismatch handshake, the clear wins.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, res_valid=0, res_match=0, res_digest=0, busy=0, err_count=0.
  - H, iv, exp and rnd are all 0.
- Latency: request accepted on edge E. res_valid rises after edge E+ROUNDS and is visible in cycle E+ROUNDS+1.
- Throughput: with res_ready held at 1, one request per ROUNDS+2 cycles. in_ready returns the cycle after the result handshake.
- Backpressure: res_ready=0 holds RESULT indefinitely. Outputs must stay stable and no new request is accepted.
- Reset mid-operation: any state returns to IDLE immediately. The pending result is discarded and err_count clears.
- Wrap: the byte add never wraps at 8 bits because it is done at 9 bits before the modular reduction. The rnd counter needs 8 bits.

## Test plan
- ROUNDS=1, in_m=0, in_iv=0, in_exp=0x85858585 -> res_digest=0x85858585, res_match=1, err_count=0; res_valid asserted exactly 2 cycles after acceptance.
- ROUNDS=1, in_m=0xFFFFFFFF, in_iv=0, in_exp=0 -> res_digest=0x87878787 (0xFF+0x85=0x184, minus 0xFD gives 0x87), res_match=0, err_count=1 after the handshake.
- ROUNDS=1, in_m=0x00000003, in_iv=0 -> res_digest=0x88858585. This checks the byte reversal: byte0=3 reduces to 0x88 and lands in byte 3.
- ROUNDS=2, in_m=0, in_iv=0, res_ready=0 for 10 cycles after res_valid -> res_digest=0x0D0D0D0D held stable, in_ready=0 throughout, no second request accepted.
- ROUNDS=24, CNT_W=2, four mismatching requests back to back -> err_count saturates at 3; clr_count pulsed on the final mismatch handshake -> err_count=0.
- rst_n asserted in cycle 5 of ROUND -> next cycle state=IDLE, in_ready=1, res_valid=0; the next request completes normally after ROUNDS+1 cycles.
